ysyx_23060278_lsu: RTL and testbench
====================================

YSYX_23060278_LSU -- requirements
Module: ysyx_23060278_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, giving the number of cycles WAIT tolerates without rsp_valid.
REQ-002 SHALL have ports, one clock, reset synchronous active-low:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  EX-stage op valid
in_ready  out  1  LSU can accept
alu_result  in  32  ALU result; effective address for memory ops
store_data  in  32  rs2 value for stores
mem_ren  in  1  load op
mem_wen  in  1  store op
mem_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
rd_in  in  5  destination register
reg_wen_in  in  1  writeback enable
out_valid  out  1  WB result valid
out_ready  in  1  WB accepts
wb_data  out  32  writeback value
rd_out  out  5  registered rd_in
reg_wen_out  out  1  writeback enable to WB
req_valid  out  1  bus request valid
req_ready  in  1  bus accepts request
req_addr  out  32  {addr[31:2],2'b00}
req_wen  out  1  1 = write
req_wdata  out  32  lane-replicated store data
req_wstrb  out  4  byte enables
rsp_valid  in  1  bus response or write ack
rsp_rdata  in  32  read word
bus_err  out  1  timeout flag, valid with out_valid
misalign  out  1  misaligned-access flag, valid with out_valid

Function
REQ-003 SHALL use FSM states IDLE, REQ, WAIT, OUT; in_ready = (state==IDLE).
REQ-004 SHALL register all inputs on in_valid&in_ready (the capture cycle).
REQ-005 SHALL, for capture with mem_ren=mem_wen=0, go IDLE->OUT with wb_data=alu_result, reg_wen_out=reg_wen_in (out_valid one cycle after capture).
REQ-006 SHALL, for memory ops, go IDLE->REQ; REQ holds req_valid=1 with stable req_* until req_ready; then WAIT.
REQ-007 SHALL leave WAIT on rsp_valid for OUT; rsp_valid outside WAIT is ignored.
REQ-008 SHALL hold OUT with stable outputs until out_ready, then return to IDLE.
REQ-009 SHALL treat mem_ren=mem_wen=1 as a load; mem_op 011/110/111 as word.
REQ-010 SHALL set req_wstrb: b = 4'b0001<<addr[1:0], h = 4'b0011<<addr[1:0] truncated to 4 bits, w = 4'b1111; loads drive req_wstrb=0.
REQ-011 SHALL drive req_wdata: b = {4{sd[7:0]}}, h = {2{sd[15:0]}}, w = sd.
REQ-012 SHALL compute load data as rsp_rdata >> (8*addr[1:0]), then sign-extend (b/h) or zero-extend (bu/hu) from bit 7/15.
REQ-013 SHALL, for stores, output wb_data=0, reg_wen_out=0.
REQ-014 SHALL count WAIT cycles with an 8-bit counter cleared on REQ->WAIT; when it reaches TIMEOUT without rsp_valid, go to OUT with bus_err=1, wb_data=0, reg_wen_out=0; rsp_valid in the same cycle wins (bus_err=0).
REQ-015 SHALL drive out_valid=1 only in OUT and req_valid=1 only in REQ.

Reset
REQ-016 SHALL, on rst_n=0 at a clock edge in any state, enter IDLE. It SHALL clear out_valid, req_valid, bus_err, misalign, reg_wen_out, wb_data, rd_out, req_* and the counter. An in-flight request is abandoned, so req_valid falls the cycle after reset.

Configuration
REQ-017 SHALL gate misalignment checking with macro YSYX_23060278_LSU_MISALIGN_CHK_EN.
REQ-018 SHALL, with the macro defined, treat h/hu with addr[0]=1 and w with addr[1:0]!=0 as misaligned. Such an op issues no bus request, goes IDLE->OUT, and sets misalign=1, wb_data=0, reg_wen_out=0.
REQ-019 SHALL, without the macro, tie misalign to 0 and perform misaligned accesses per REQ-010/012 (truncated lanes).

Verification
REQ-020 SHALL cover: lb addr 0x8000_0003, rsp_rdata 0x80AA_BBCC -> req_addr 0x8000_0000, wb_data 0xFFFF_FF80.
REQ-021 SHALL cover: sh addr 0x8000_0002, store_data 0x1234_5678 -> req_wstrb 4'b1100, req_wdata 0x5678_5678, reg_wen_out 0.
REQ-022 SHALL cover: non-memory op alu_result 0x0000_0042, out_ready held 0 for 3 cycles -> out_valid after 1 cycle, wb_data stable 0x42, in_ready 0 until handshake.
REQ-023 SHALL cover: req_ready withheld 5 cycles, no rsp for TIMEOUT=4 -> req_valid held 5 cycles, bus_err=1, wb_data 0.
REQ-024 SHALL cover: rst_n low one cycle during WAIT, then late rsp_valid -> IDLE, out_valid stays 0.
REQ-025 SHALL cover: lw addr 0x8000_0001 -> with the macro, misalign=1 and req_valid never asserted; without it, misalign=0 and one bus request.

Source files
------------

// File: rtl/ysyx_23060278_lsu.sv
// ysyx_23060278_lsu -- load/store unit between EX and WB.
//
// Accepts one operation at a time from EX. Non-memory operations pass the
// ALU result straight to WB. Loads and stores issue a single word-aligned
// bus request, wait for the response (bounded by TIMEOUT cycles), then
// present the result to WB until it is accepted.
//
// Parameters:
//   TIMEOUT     cycles WAIT tolerates without rsp_valid before flagging bus_err
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               EX handshake
//   alu_result, store_data          effective address, rs2 value
//   mem_ren, mem_wen, mem_op        load/store select, funct3 size/sign
//   rd_in, reg_wen_in               destination register and its write enable
//   out_valid/out_ready             WB handshake
//   wb_data, rd_out, reg_wen_out    writeback value, register, enable
//   req_valid/req_ready             bus request handshake
//   req_addr, req_wen, req_wdata,
//   req_wstrb                       word address, write flag, data, byte enables
//   rsp_valid, rsp_rdata            bus response / write ack and read word
//   bus_err, misalign               status flags, valid with out_valid
//
// Configuration:
//   YSYX_23060278_LSU_MISALIGN_CHK_EN  when defined, misaligned h/hu/w accesses
//                                      skip the bus and report misalign=1;
//                                      otherwise misalign is tied to 0.

module ysyx_23060278_lsu #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [2:0]  mem_op,
    input  logic [4:0]  rd_in,
    input  logic        reg_wen_in,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        reg_wen_out,

    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    output logic        req_wen,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,

    output logic        bus_err,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t      state_q;

    // captured operation attributes needed after the capture cycle
    logic [1:0]  off_q;
    logic [2:0]  op_q;
    logic        store_q;
    logic        reg_wen_q;
    logic [7:0]  cnt_q;

    // registered outputs
    logic [31:0] wb_data_q;
    logic [4:0]  rd_q;
    logic        reg_wen_out_q;
    logic        bus_err_q;
    logic [31:0] req_addr_q;
    logic        req_wen_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;
`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
    logic        misalign_q;
`endif

    // decode of the incoming operation
    logic        in_mem;
    logic        in_store;
    logic        in_mis;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;

    // load data extraction from the response word
    logic [31:0] rsp_shifted;
    logic [31:0] ld_data;

    always_comb begin
        in_mem   = mem_ren | mem_wen;
        // both enables set is treated as a load
        in_store = mem_wen & ~mem_ren;

        unique case (mem_op[1:0])
            2'b00: begin
                in_wstrb = 4'b0001 << alu_result[1:0];
                in_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                // upper lane bits shifted past bit 3 are dropped
                in_wstrb = 4'b0011 << alu_result[1:0];
                in_wdata = {2{store_data[15:0]}};
            end
            default: begin
                in_wstrb = 4'b1111;
                in_wdata = store_data;
            end
        endcase
        if (!in_store) begin
            in_wstrb = '0;
        end

`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
        in_mis = in_mem &
                 (((mem_op[1:0] == 2'b01) & alu_result[0]) |
                  (mem_op[1] & (alu_result[1:0] != 2'b00)));
`else
        in_mis = 1'b0;
`endif
    end

    always_comb begin
        rsp_shifted = rsp_rdata >> {off_q, 3'b000};
        unique case (op_q[1:0])
            2'b00:   ld_data = op_q[2] ? {24'b0, rsp_shifted[7:0]}
                                       : {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
            2'b01:   ld_data = op_q[2] ? {16'b0, rsp_shifted[15:0]}
                                       : {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
            default: ld_data = rsp_shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            off_q         <= '0;
            op_q          <= '0;
            store_q       <= 1'b0;
            reg_wen_q     <= 1'b0;
            cnt_q         <= '0;
            wb_data_q     <= '0;
            rd_q          <= '0;
            reg_wen_out_q <= 1'b0;
            bus_err_q     <= 1'b0;
            req_addr_q    <= '0;
            req_wen_q     <= 1'b0;
            req_wdata_q   <= '0;
            req_wstrb_q   <= '0;
`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        off_q     <= alu_result[1:0];
                        op_q      <= mem_op;
                        store_q   <= in_store;
                        reg_wen_q <= reg_wen_in;
                        rd_q      <= rd_in;
                        bus_err_q <= 1'b0;
`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
                        misalign_q <= in_mis;
`endif
                        if (!in_mem || in_mis) begin
                            // no bus traffic: result is known at capture
                            wb_data_q     <= in_mem ? '0 : alu_result;
                            reg_wen_out_q <= in_mem ? 1'b0 : reg_wen_in;
                            state_q       <= S_OUT;
                        end else begin
                            req_addr_q    <= {alu_result[31:2], 2'b00};
                            req_wen_q     <= in_store;
                            req_wdata_q   <= in_wdata;
                            req_wstrb_q   <= in_wstrb;
                            wb_data_q     <= '0;
                            reg_wen_out_q <= 1'b0;
                            state_q       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (req_ready) begin
                        cnt_q   <= '0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // a response arriving on the timeout cycle still wins
                    if (rsp_valid) begin
                        wb_data_q     <= store_q ? '0 : ld_data;
                        reg_wen_out_q <= ~store_q & reg_wen_q;
                        state_q       <= S_OUT;
                    end else if (cnt_q == TIMEOUT) begin
                        bus_err_q     <= 1'b1;
                        wb_data_q     <= '0;
                        reg_wen_out_q <= 1'b0;
                        state_q       <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_OUT);
    assign req_valid   = (state_q == S_REQ);
    assign wb_data     = wb_data_q;
    assign rd_out      = rd_q;
    assign reg_wen_out = reg_wen_out_q;
    assign bus_err     = bus_err_q;
    assign req_addr    = req_addr_q;
    assign req_wen     = req_wen_q;
    assign req_wdata   = req_wdata_q;
    assign req_wstrb   = req_wstrb_q;
`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
    assign misalign    = misalign_q;
`else
    assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_23060278_lsu.sv
// Self-checking bench for ysyx_23060278_lsu (TIMEOUT overridden to 4).
// Expected results are queued when an operation is issued and popped when
// the DUT presents out_valid.

module tb_ysyx_23060278_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_ren;
    logic        mem_wen;
    logic [2:0]  mem_op;
    logic [4:0]  rd_in;
    logic        reg_wen_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;
    logic        reg_wen_out;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        bus_err;
    logic        misalign;

    int total = 0;
    int bad   = 0;
    int req_fires = 0;

    typedef struct packed {
        logic [31:0] wb;
        logic        rwen;
        logic [4:0]  rd;
        logic        berr;
        logic        mis;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    ysyx_23060278_lsu #(.TIMEOUT(8'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .mem_ren     (mem_ren),
        .mem_wen     (mem_wen),
        .mem_op      (mem_op),
        .rd_in       (rd_in),
        .reg_wen_in  (reg_wen_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .wb_data     (wb_data),
        .rd_out      (rd_out),
        .reg_wen_out (reg_wen_out),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_wen     (req_wen),
        .req_wdata   (req_wdata),
        .req_wstrb   (req_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .bus_err     (bus_err),
        .misalign    (misalign)
    );

    // counts accepted bus requests
    always @(posedge clk) begin
        if (rst_n && req_valid && req_ready) req_fires <= req_fires + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] s;
        s = rdata >> (32'(off) * 8);
        case (op)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] op, input logic [1:0] off,
                                               input logic store);
        logic [3:0] w;
        if (!store) return 4'b0000;
        case (op[1:0])
            2'b00:   w = 4'b0001 << off;
            2'b01:   w = 4'b0011 << off;
            default: w = 4'b1111;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] sd);
        case (op[1:0])
            2'b00:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            2'b01:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_op(input logic ren, input logic wen, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [4:0] rd, input logic rwen);
        in_valid   = 1'b1;
        mem_ren    = ren;
        mem_wen    = wen;
        mem_op     = op;
        alu_result = addr;
        store_data = sd;
        rd_in      = rd;
        reg_wen_in = rwen;
        tick();
        in_valid   = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
    endtask

    task automatic accept_req();
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] rdata);
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        tick();
        rsp_valid = 1'b0;
    endtask

    task automatic wait_out(input int bound, output int n);
        n = 0;
        while (!out_valid && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++;
        if ({in_ready, out_valid, req_valid, bus_err, misalign, reg_wen_out} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 100000",
                     {in_ready, out_valid, req_valid, bus_err, misalign, reg_wen_out});
        end
        total++;
        if ({wb_data, rd_out, req_addr, req_wdata, req_wstrb, req_wen} !== 106'h0) begin
            bad++;
            $display("FAIL reset_data: got wb=%h rd=%h addr=%h wdata=%h wstrb=%b wen=%b want all 0",
                     wb_data, rd_out, req_addr, req_wdata, req_wstrb, req_wen);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        exp_t e;
        int n;
        sb_q.push_back('{wb: 32'hFFFF_FF80, rwen: 1'b1, rd: 5'd5, berr: 1'b0, mis: 1'b0});
        drive_op(1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 1'b1);
        total++;
        if ({req_valid, in_ready, req_addr, req_wen, req_wstrb} !== {1'b1, 1'b0, 32'h8000_0000, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL lb_req: got v=%b rdy=%b addr=%h wen=%b wstrb=%b want v=1 rdy=0 addr=80000000 wen=0 wstrb=0000",
                     req_valid, in_ready, req_addr, req_wen, req_wstrb);
        end
        accept_req();
        respond(32'h80AA_BBCC);
        wait_out(20, n);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL lb_timeout: out_valid=%b after %0d cycles want 1", out_valid, n);
        end
        e = sb_q.pop_front();
        total++;
        if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
            bad++;
            $display("FAIL lb_result: got %h want %h", {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
        end
        handshake_out();
    endtask

    task automatic test_sh();
        exp_t e;
        int n;
        sb_q.push_back('{wb: 32'h0, rwen: 1'b0, rd: 5'd6, berr: 1'b0, mis: 1'b0});
        drive_op(1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 5'd6, 1'b1);
        // request must stay stable while req_ready is withheld
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({req_valid, req_addr, req_wen, req_wstrb, req_wdata} !==
                {1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'h5678_5678}) begin
                bad++;
                $display("FAIL sh_req[%0d]: got v=%b addr=%h wen=%b wstrb=%b wdata=%h want v=1 addr=80000000 wen=1 wstrb=1100 wdata=56785678",
                         i, req_valid, req_addr, req_wen, req_wstrb, req_wdata);
            end
            if (i < 2) tick();
        end
        accept_req();
        respond(32'hDEAD_BEEF);
        wait_out(20, n);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL sh_timeout: out_valid=%b after %0d cycles want 1", out_valid, n);
        end
        e = sb_q.pop_front();
        total++;
        if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
            bad++;
            $display("FAIL sh_result: got %h want %h", {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
        end
        handshake_out();
    endtask

    task automatic test_nonmem();
        exp_t e;
        sb_q.push_back('{wb: 32'h0000_0042, rwen: 1'b1, rd: 5'd7, berr: 1'b0, mis: 1'b0});
        drive_op(1'b0, 1'b0, 3'b010, 32'h0000_0042, 32'h0, 5'd7, 1'b1);
        // out_ready held low 3 cycles; stray rsp_valid must be ignored
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({out_valid, in_ready, req_valid, wb_data} !== {1'b1, 1'b0, 1'b0, 32'h0000_0042}) begin
                bad++;
                $display("FAIL nonmem_hold[%0d]: got ov=%b ir=%b rv=%b wb=%h want ov=1 ir=0 rv=0 wb=00000042",
                         i, out_valid, in_ready, req_valid, wb_data);
            end
            rsp_valid = 1'b1;
            rsp_rdata = 32'hFFFF_0000 | 32'(i);
            tick();
            rsp_valid = 1'b0;
        end
        e = sb_q.pop_front();
        total++;
        if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
            bad++;
            $display("FAIL nonmem_result: got %h want %h", {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
        end
        handshake_out();
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL nonmem_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        int nreq;
        sb_q.push_back('{wb: 32'h0, rwen: 1'b0, rd: 5'd3, berr: 1'b1, mis: 1'b0});
        drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'h0, 5'd3, 1'b1);
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_valid) nreq++;
            tick();
        end
        total++;
        if (nreq != 5 || req_valid !== 1'b1) begin
            bad++;
            $display("FAIL timeout_reqhold: got %0d cycles (still %b) want 5 cycles (still 1)", nreq, req_valid);
        end
        accept_req();
        wait_out(20, n);
        total++;
        if (out_valid !== 1'b1 || n < 4 || n > 5) begin
            bad++;
            $display("FAIL timeout_latency: out_valid=%b after %0d wait cycles want 1 after 4..5", out_valid, n);
        end
        e = sb_q.pop_front();
        total++;
        if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
            bad++;
            $display("FAIL timeout_result: got %h want %h", {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
        end
        handshake_out();
    endtask

    task automatic test_reset_wait();
        logic seen;
        // reset in WAIT, then a late response
        drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'h0, 5'd4, 1'b1);
        accept_req();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({in_ready, out_valid, req_valid, bus_err} !== 4'b1000) begin
            bad++;
            $display("FAIL rstwait_state: got %b want 1000", {in_ready, out_valid, req_valid, bus_err});
        end
        respond(32'h1234_5678);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen = 1'b1;
            tick();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rstwait_late_rsp: got out_valid/in_ready disturbed=%b want 0", seen);
        end
        // reset in REQ drops req_valid the next cycle
        drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0030, 32'h0, 5'd4, 1'b1);
        total++;
        if (req_valid !== 1'b1) begin
            bad++;
            $display("FAIL rstreq_pre: got req_valid=%b want 1", req_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({req_valid, in_ready, out_valid} !== 3'b010) begin
            bad++;
            $display("FAIL rstreq_post: got %b want 010", {req_valid, in_ready, out_valid});
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        int n;
        int start;
        int want_fires;
`ifdef YSYX_23060278_LSU_MISALIGN_CHK_EN
        sb_q.push_back('{wb: 32'h0, rwen: 1'b0, rd: 5'd9, berr: 1'b0, mis: 1'b1});
        want_fires = 0;
`else
        sb_q.push_back('{wb: 32'h0011_2233, rwen: 1'b1, rd: 5'd9, berr: 1'b0, mis: 1'b0});
        want_fires = 1;
`endif
        start = req_fires;
        drive_op(1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 5'd9, 1'b1);
`ifndef YSYX_23060278_LSU_MISALIGN_CHK_EN
        accept_req();
        respond(32'h1122_3344);
`endif
        wait_out(20, n);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL misalign_timeout: out_valid=%b after %0d cycles want 1", out_valid, n);
        end
        e = sb_q.pop_front();
        total++;
        if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
            bad++;
            $display("FAIL misalign_result: got %h want %h", {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
        end
        total++;
        if (req_fires - start != want_fires) begin
            bad++;
            $display("FAIL misalign_reqs: got %0d bus requests want %0d", req_fires - start, want_fires);
        end
        handshake_out();
    endtask

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } row_t;

    task automatic test_back_to_back();
        row_t t[10];
        exp_t e;
        logic st;
        int n;
        t[0] = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0,         32'hA1B2_C3D4, 5'd10};
        t[1] = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_1234, 5'd11};
        t[2] = '{1'b1, 1'b0, 3'b101, 32'h0000_0300, 32'h0,         32'h0000_F00F, 5'd12};
        t[3] = '{1'b0, 1'b1, 3'b000, 32'h0000_0403, 32'h0000_00AB, 32'h5555_5555, 5'd13};
        t[4] = '{1'b1, 1'b1, 3'b011, 32'h0000_0500, 32'h1111_1111, 32'hCAFE_F00D, 5'd14};
        t[5] = '{1'b1, 1'b0, 3'b000, 32'h0000_0600, 32'h0,         32'h0000_007F, 5'd15};
        t[6] = '{1'b0, 1'b1, 3'b010, 32'h0000_0704, 32'hDEAD_BEEF, 32'h0,         5'd16};
        t[7] = '{1'b1, 1'b0, 3'b110, 32'h0000_0808, 32'h0,         32'h0102_0304, 5'd17};
        t[8] = '{1'b0, 1'b1, 3'b001, 32'h0000_0900, 32'h0000_BEEF, 32'h0,         5'd18};
        t[9] = '{1'b1, 1'b0, 3'b101, 32'h0000_0A02, 32'h0,         32'h9ABC_0000, 5'd19};
        for (int i = 0; i < 10; i++) begin
            st = t[i].wen & ~t[i].ren;
            e.wb   = st ? 32'h0 : model_load(t[i].op, t[i].addr[1:0], t[i].rdata);
            e.rwen = ~st;
            e.rd   = t[i].rd;
            e.berr = 1'b0;
            e.mis  = 1'b0;
            sb_q.push_back(e);
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got in_ready=%b want 1", i, in_ready);
            end
            drive_op(t[i].ren, t[i].wen, t[i].op, t[i].addr, t[i].sd, t[i].rd, 1'b1);
            total++;
            if ({req_valid, req_addr, req_wen, req_wstrb} !==
                {1'b1, t[i].addr & 32'hFFFF_FFFC, st, model_wstrb(t[i].op, t[i].addr[1:0], st)}) begin
                bad++;
                $display("FAIL b2b_req[%0d]: got v=%b addr=%h wen=%b wstrb=%b want v=1 addr=%h wen=%b wstrb=%b",
                         i, req_valid, req_addr, req_wen, req_wstrb, t[i].addr & 32'hFFFF_FFFC, st,
                         model_wstrb(t[i].op, t[i].addr[1:0], st));
            end
            if (st) begin
                total++;
                if (req_wdata !== model_wdata(t[i].op, t[i].sd)) begin
                    bad++;
                    $display("FAIL b2b_wdata[%0d]: got %h want %h", i, req_wdata, model_wdata(t[i].op, t[i].sd));
                end
            end
            accept_req();
            respond(t[i].rdata);
            wait_out(20, n);
            total++;
            if (out_valid !== 1'b1) begin
                bad++;
                $display("FAIL b2b_timeout[%0d]: out_valid=%b after %0d cycles want 1", i, out_valid, n);
            end
            e = sb_q.pop_front();
            total++;
            if ({wb_data, reg_wen_out, rd_out, bus_err, misalign} !== e) begin
                bad++;
                $display("FAIL b2b_result[%0d]: got %h want %h", i,
                         {wb_data, reg_wen_out, rd_out, bus_err, misalign}, e);
            end
            handshake_out();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        alu_result = '0;
        store_data = '0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        mem_op     = '0;
        rd_in      = '0;
        reg_wen_in = 1'b0;
        out_ready  = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        tick();

        test_reset();
        test_lb();
        test_sh();
        test_nonmem();
        test_timeout();
        test_reset_wait();
        test_misalign();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
